// File: rtl/echo_delay_line.sv
// echo_delay_line: programmable echo on an offset-binary audio stream.
// A circular sample buffer in inferred RAM provides a delayed copy of
// the signal. The copy is attenuated by an arithmetic shift and added to
// the input with saturation. Mode 0 stores the dry input (single echo).
// Mode 1 stores the output (decaying repeated echo). Fixed latency is
// two sysclk cycles from data_valid to out_valid.
module echo_delay_line #(
   parameter int               WIDTH      = 10,
   parameter int               ADDR_W     = 13,
   parameter logic [WIDTH-1:0] ADC_OFFSET = 10'h181,
   parameter logic [WIDTH-1:0] DAC_OFFSET = 10'h200
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              data_valid,
   input  logic [WIDTH-1:0]  data_in,
   input  logic [ADDR_W-1:0] delay_len,
   input  logic [2:0]        attn_shift,
   input  logic              mode,
   input  logic              enable,
   output logic [WIDTH-1:0]  data_out,
   output logic              out_valid,
   output logic              filled
);

   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] MIN_DELAY = ADDR_W'(3);

   // Sample buffer; contents are never cleared, the fill gating hides stale data
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [WIDTH-1:0]  r_rd_data;

   // S1 stage: sample and its configuration captured on the data_valid cycle
   logic              r_v1;
   logic [WIDTH-1:0]  r_x1;
   logic              r_en1;
   logic              r_mode1;
   logic [2:0]        r_attn1;
   logic              r_byp1;

   // Buffer bookkeeping and registered copies used to detect reconfiguration
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_fill_cnt;
   logic              r_filled;
   logic [ADDR_W-1:0] r_delay_len;
   logic              r_mode;

   // Output register
   logic [WIDTH-1:0]  r_data_out;
   logic              r_out_valid;

   logic [WIDTH-1:0]        w_x;
   logic [ADDR_W-1:0]       w_deff;
   logic                    w_refill;
   logic                    w_bypass0;
   logic                    w_wr_pending;
   logic [ADDR_W-1:0]       w_rd_addr;
   logic signed [WIDTH-1:0] w_d;
   logic signed [WIDTH-1:0] w_d_shift;
   logic [WIDTH:0]          w_sum;
   logic                    w_ovf;
   logic [WIDTH-1:0]        w_y;
   logic                    w_fill_inc;
   logic [ADDR_W-1:0]       w_fill_next;
   logic                    w_filled_next;

   // Signed sample from the offset-binary ADC code (wraps modulo 2^WIDTH)
   assign w_x = data_in - ADC_OFFSET;

   // Effective delay: 0 bypasses; short delays are stretched so a read never
   // targets a slot whose write-back is still in the pipeline
   assign w_deff = (delay_len == '0)        ? '0 :
                   (delay_len < MIN_DELAY)  ? MIN_DELAY : delay_len;

   assign w_refill  = (delay_len != r_delay_len) | (mode != r_mode) | ~enable;
   assign w_bypass0 = ~enable | (w_deff == '0);

   // The sample in S1 writes at the coming edge, so a sample entering S0 on
   // the same cycle owns the slot after the current write pointer
   assign w_wr_pending = r_v1 & r_en1;
   assign w_rd_addr    = r_wr_ptr + {{(ADDR_W-1){1'b0}}, w_wr_pending} - w_deff;

   // Delayed term, attenuated; silence until the buffer holds D_eff samples
   assign w_d       = (r_filled & ~r_byp1) ? $signed(r_rd_data) : '0;
   assign w_d_shift = w_d >>> r_attn1;

   // One extra bit absorbs the sum; clamp when the top two bits disagree
   assign w_sum = {r_x1[WIDTH-1], r_x1} + {w_d_shift[WIDTH-1], w_d_shift};
   assign w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
   assign w_y   = w_ovf ? {w_sum[WIDTH], {(WIDTH-1){~w_sum[WIDTH]}}}
                        : w_sum[WIDTH-1:0];

   // Fill count saturates at D_eff; filled is evaluated against the same count
   assign w_fill_inc    = w_wr_pending & (r_fill_cnt < w_deff);
   assign w_fill_next   = r_fill_cnt + {{(ADDR_W-1){1'b0}}, w_fill_inc};
   assign w_filled_next = (w_deff != '0) & (w_fill_next >= w_deff);

   // Buffer RAM: write back the S1 result, registered read of the delayed tap
   always_ff @(posedge sysclk) begin
      if (w_wr_pending && !reset) begin
         r_mem[r_wr_ptr] <= r_mode1 ? w_y : r_x1;
      end
      if (data_valid) begin
         r_rd_data <= r_mem[w_rd_addr];
      end
   end

   // Capture the accepted sample and the configuration it is processed with
   always_ff @(posedge sysclk) begin
      if (data_valid) begin
         r_x1    <= w_x;
         r_en1   <= enable;
         r_mode1 <= mode;
         r_attn1 <= attn_shift;
         r_byp1  <= w_bypass0;
      end
   end

   // Pipeline valids, output register, write pointer and fill tracking
   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_v1        <= 1'b0;
         r_out_valid <= 1'b0;
         r_data_out  <= DAC_OFFSET;
         r_wr_ptr    <= '0;
         r_fill_cnt  <= '0;
         r_filled    <= 1'b0;
         r_delay_len <= '0;
         r_mode      <= 1'b0;
      end else begin
         r_v1        <= data_valid;
         r_out_valid <= r_v1;
         if (r_v1) begin
            r_data_out <= w_y + DAC_OFFSET;
         end
         if (w_wr_pending) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         r_delay_len <= delay_len;
         r_mode      <= mode;
         if (w_refill) begin
            r_fill_cnt <= '0;
            r_filled   <= 1'b0;
         end else begin
            r_fill_cnt <= w_fill_next;
            r_filled   <= w_filled_next;
         end
      end
   end

   assign data_out  = r_data_out;
   assign out_valid = r_out_valid;
   assign filled    = r_filled;

endmodule

// File: tb/tb_echo_delay_line.sv
// Bench for echo_delay_line: directed scenarios plus randomized traffic.
// Expected outputs come from a sample-level model that keeps the values
// written since the last refill in a queue. A negedge monitor pops the
// scoreboard and compares value and latency on every out_valid.
module tb_echo_delay_line;

   localparam int WIDTH  = 10;
   localparam int ADDR_W = 4;

   logic              sysclk = 1'b0;
   logic              reset;
   logic              data_valid;
   logic [WIDTH-1:0]  data_in;
   logic [ADDR_W-1:0] delay_len;
   logic [2:0]        attn_shift;
   logic              mode;
   logic              enable;
   logic [WIDTH-1:0]  data_out;
   logic              out_valid;
   logic              filled;

   echo_delay_line #(
      .WIDTH      (WIDTH),
      .ADDR_W     (ADDR_W),
      .ADC_OFFSET (10'h181),
      .DAC_OFFSET (10'h200)
   ) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .data_valid (data_valid),
      .data_in    (data_in),
      .delay_len  (delay_len),
      .attn_shift (attn_shift),
      .mode       (mode),
      .enable     (enable),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .filled     (filled)
   );

   always #5 sysclk = ~sysclk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int txn      = 0;

   always @(posedge sysclk) cyc <= cyc + 1;

   typedef struct {
      int data;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   // Model state: values stored in the buffer since the last refill
   int hist[$];
   int prev_delay;
   int prev_mode;
   bit cfg_known;

   function automatic int to_x(input logic [9:0] din);
      int v;
      v = int'(din) - 'h181;
      if (v > 511) v -= 1024;
      if (v < -512) v += 1024;
      return v;
   endfunction

   function automatic int deff_of(input int dl);
      if (dl == 0) return 0;
      if (dl < 3) return 3;
      return dl;
   endfunction

   // One sample through the echo rule; returns y
   function automatic int model_step(input int x);
      int deff;
      int d;
      int s;
      deff = deff_of(int'(delay_len));
      if (!cfg_known || int'(delay_len) != prev_delay ||
          int'(mode) != prev_mode || !enable) begin
         hist.delete();
      end
      prev_delay = int'(delay_len);
      prev_mode  = int'(mode);
      cfg_known  = 1'b1;
      d = 0;
      if (enable && deff != 0 && hist.size() >= deff) d = hist[hist.size() - deff];
      s = x + (d >>> attn_shift);
      if (s > 511) s = 511;
      if (s < -512) s = -512;
      if (enable) begin
         hist.push_back(mode ? s : x);
         if (hist.size() > 40) void'(hist.pop_front());
      end
      return s;
   endfunction

   // Scoreboard monitor
   always @(negedge sysclk) begin
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_out_valid cyc=%0d data_out=0x%03h required=no output", cyc, data_out);
         end else begin
            mon_e = sb.pop_front();
            txn++;
            $display("txn %0d cyc=%0d data_out=0x%03h expected=0x%03h filled=%0b",
                     txn, cyc, data_out, mon_e.data[9:0], filled);
            checks++;
            if (data_out !== 10'(mon_e.data)) begin
               failures++;
               $display("FAIL data_out txn=%0d got=0x%03h required=0x%03h", txn, data_out, mon_e.data[9:0]);
            end
            checks++;
            if (cyc != mon_e.cyc + 2) begin
               failures++;
               $display("FAIL latency txn=%0d got=%0d required=2", txn, cyc - mon_e.cyc);
            end
         end
      end
   end

   task automatic set_cfg(input int dl, input bit md, input int at, input bit en);
      delay_len  = ADDR_W'(dl);
      mode       = md;
      attn_shift = 3'(at);
      enable     = en;
   endtask

   // Issue one strobe; optional filled check once the sample has been written
   task automatic send(input logic [9:0] din, input int gap, input bit chk_filled);
      int  y;
      bit  fexp;
      int  deff;
      data_in    = din;
      data_valid = 1'b1;
      y    = model_step(to_x(din));
      deff = deff_of(int'(delay_len));
      fexp = enable && deff != 0 && hist.size() >= deff;
      sb.push_back('{data: y + 512, cyc: cyc});
      @(posedge sysclk);
      #1;
      data_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
         @(posedge sysclk);
         #1;
         if (chk_filled && i == 0) begin
            checks++;
            if (filled !== fexp) begin
               failures++;
               $display("FAIL filled cyc=%0d got=%0b required=%0b", cyc, filled, fexp);
            end
         end
      end
   endtask

   task automatic do_reset(input int n, input bit chk);
      reset      = 1'b1;
      data_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge sysclk);
         #1;
         if (chk) begin
            checks += 3;
            if (data_out !== 10'h200) begin
               failures++;
               $display("FAIL reset_data_out got=0x%03h required=0x200", data_out);
            end
            if (out_valid !== 1'b0) begin
               failures++;
               $display("FAIL reset_out_valid got=%0b required=0", out_valid);
            end
            if (filled !== 1'b0) begin
               failures++;
               $display("FAIL reset_filled got=%0b required=0", filled);
            end
         end
      end
      reset = 1'b0;
      sb.delete();
      hist.delete();
      cfg_known = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) begin
         @(posedge sysclk);
         #1;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      logic [9:0] v;
      int         g;
      reset      = 1'b1;
      data_valid = 1'b0;
      data_in    = 10'h181;
      set_cfg(4, 1'b0, 1, 1'b1);
      cfg_known  = 1'b0;

      // Reset state and plain strobes at midscale
      do_reset(3, 1'b1);
      for (int i = 0; i < 3; i++) send(10'h181, 3, 1'b1);
      drain();

      // Feed-forward single echo
      do_reset(2, 1'b0);
      set_cfg(4, 1'b0, 1, 1'b1);
      send(10'h1E5, 2, 1'b1);
      for (int i = 0; i < 9; i++) send(10'h181, 2, 1'b1);
      drain();

      // Feedback decay, mixed strobe spacing
      do_reset(2, 1'b0);
      set_cfg(4, 1'b1, 1, 1'b1);
      send(10'h1E5, 1, 1'b1);
      for (int i = 0; i < 28; i++) send(10'h181, i % 3, 1'b1);
      drain();

      // Saturation both ways
      do_reset(2, 1'b0);
      set_cfg(3, 1'b0, 0, 1'b1);
      for (int i = 0; i < 6; i++) send(10'h311, 1, 1'b1);
      do_reset(2, 1'b0);
      set_cfg(3, 1'b0, 0, 1'b1);
      for (int i = 0; i < 6; i++) send(10'h3F1, 1, 1'b1);
      drain();

      // Mid-run reconfiguration of delay length
      do_reset(2, 1'b0);
      set_cfg(4, 1'b0, 1, 1'b1);
      for (int i = 0; i < 10; i++) send(10'($urandom_range('h0C0, 'h2C0)), 1, 1'b1);
      set_cfg(6, 1'b0, 1, 1'b1);
      for (int i = 0; i < 10; i++) send(10'($urandom_range('h0C0, 'h2C0)), 1, 1'b1);
      set_cfg(1, 1'b0, 1, 1'b1);
      for (int i = 0; i < 8; i++) send(10'($urandom_range('h0C0, 'h2C0)), 0, 1'b0);
      drain();

      // Pointer wrap with back-to-back strobes, then a one-sample disable
      do_reset(2, 1'b0);
      set_cfg(15, 1'b0, 2, 1'b1);
      for (int i = 0; i < 40; i++) begin
         v = 10'('h181 - 200 + i * 10);
         send(v, 0, 1'b0);
      end
      enable = 1'b0;
      send(10'h200, 0, 1'b0);
      enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         v = 10'('h181 + i * 9);
         send(v, 0, 1'b0);
      end
      drain();

      // Randomized traffic with occasional reconfiguration and resets
      do_reset(2, 1'b0);
      set_cfg(5, 1'b0, 1, 1'b1);
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            set_cfg($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), $urandom_range(0, 9) != 0);
         end else if ($urandom_range(0, 9) == 0) begin
            attn_shift = 3'($urandom_range(0, 7));
         end
         g = $urandom_range(0, 2);
         send(10'($urandom), g, g >= 1);
         if ($urandom_range(0, 49) == 0) do_reset(1, 1'b0);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d required=finish before timeout", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/echo_delay_line.md
Name: echo_delay_line

Overview:
Parametrised successor to the single-tap delay processor in the audio path between ADC capture and DAC output. It holds a programmable-length circular sample buffer in inferred RAM. Output is the input plus an attenuated delayed copy, in one of two modes: feed-forward (single echo) or feedback (decaying repeated echo). Delay, attenuation and mode are run-time inputs. A sample strobe decouples the sample rate from sysclk.

Parameters:
WIDTH, 10, sample width in bits (data_in, data_out, internal signed samples).
ADDR_W, 13, buffer address width; buffer depth = 2^ADDR_W samples.
ADC_OFFSET, 10'h181, offset subtracted from data_in to form signed x.
DAC_OFFSET, 10'h200, offset added to signed y to form data_out.

Ports:
sysclk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous reset, active-high.
data_valid  in  1  one-cycle strobe; data_in is accepted on that cycle.
data_in  in  WIDTH  offset-binary ADC sample.
delay_len  in  ADDR_W  delay in samples; 0 = bypass.
attn_shift  in  3  arithmetic right shift applied to the delayed term (0..7).
mode  in  1  0 = feed-forward (store x), 1 = feedback (store y).
enable  in  1  0 = dry pass-through, no buffer writes.
data_out  out  WIDTH  offset-binary DAC sample, registered.
out_valid  out  1  high for one cycle when data_out updates.
filled  out  1  buffer holds at least D_eff valid samples.

Behaviour:
- Reset (synchronous, active-high):
  - wr_ptr = 0, fill_cnt = 0, filled = 0.
  - Pipeline valid bits cleared, out_valid = 0.
  - data_out = DAC_OFFSET (midscale silence).
  - RAM contents are not cleared; the filled gating makes them irrelevant.
- Input and delay:
  - x = data_in - ADC_OFFSET, interpreted as signed WIDTH bits.
  - D_eff = 0 if delay_len == 0; otherwise max(delay_len, 3).
  - The minimum of 3 covers the write-back latency. delay_len of 1 or 2 therefore behaves as 3 in both modes.
- Pipeline, fixed latency 2 cycles (out_valid is data_valid delayed by 2):
  - S0 (data_valid cycle): register x. Issue RAM read at address wr_ptr - D_eff, modulo 2^ADDR_W.
  - S1: d = RAM data if filled, else 0. sum = x + (d >>> attn_shift), computed at WIDTH+1 bits. y = sum saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - S2: data_out <= y + DAC_OFFSET (mod 2^WIDTH), out_valid <= 1. If enable, write RAM[wr_ptr] <= (mode ? y : x) and wr_ptr <= wr_ptr + 1 (wraps at 2^ADDR_W).
- Fill control:
  - fill_cnt increments on each buffer write and saturates at D_eff.
  - filled = (fill_cnt >= D_eff) && (D_eff != 0).
  - The sample with index D_eff after a refill is the first to see a nonzero d.
- Refill trigger: any change of delay_len or mode (against the registered copy), or enable = 0. Effect next cycle: fill_cnt = 0, filled = 0. wr_ptr is not reset. attn_shift changes take effect immediately without a refill.
- Bypass: enable = 0 or D_eff = 0 gives y = x, with latency and out_valid unchanged.
- Strobe spacing: data_valid may be asserted on back-to-back cycles. The D_eff >= 3 rule guarantees a RAM read never needs a value not yet written.
- Simultaneous events:
  - reset overrides everything.
  - data_valid on the same cycle as a refill trigger: the sample is processed with d = 0 and counts as the first fill write.
  - reset mid-stream discards in-flight samples; no out_valid until two cycles after the next data_valid.

Test Plan:
1. Reset asserted 3 cycles, then data_valid strobes at data_in = 0x181 -> during reset data_out = 0x200, out_valid = 0, filled = 0. Afterwards out_valid pulses exactly 2 cycles after each strobe.
2. Feed-forward echo: mode = 0, delay_len = 4, attn_shift = 1, impulse data_in = 0x1E5 (x = 100) at sample 0, then 0x181 -> data_out 0x264, 0x200 x3, 0x232 at sample 4, then 0x200. filled rises after the 4th write.
3. Feedback decay: mode = 1, delay_len = 4, attn_shift = 1, same impulse -> echoes of +50, +25, +12, +6, +3, +1 at samples 4, 8, 12, 16, 20, 24 (0x232, 0x219, 0x20C, ...), then 0x200.
4. Saturation: mode = 0, delay_len = 3, attn_shift = 0, constant data_in = 0x311 (x = 400) -> data_out 0x390 for 3 samples, then 0x3FF. Constant x = -400 -> data_out 0x070, then 0x000.
5. Mid-run reconfiguration: steady echo at delay_len = 4, switch to delay_len = 6 -> filled drops the next cycle and the next 6 outputs are dry (y = x). Delayed terms resume from the 7th sample. delay_len = 1 -> echo observed at 3 samples.
6. Wrap and back-to-back: ADDR_W = 4, delay_len = 15, mode = 0, attn_shift = 2, 40-sample ramp with data_valid every cycle -> every output equals sat(x[n] + (x[n-15] >>> 2)) + 0x200 across pointer wrap. enable = 0 for 1 sample forces a refill (15 dry outputs).
